// File: rtl/exec_pipeline_ctrl.sv
// Hazard/sequencing controller around the execute stage of an IF/ID/EX/WB pipe:
// stalls, kills, operand forwarding selects, PC redirect and perf counters.
module exec_pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_we,
    input  logic             ex_is_load,
    input  logic             ex_do_jump,
    input  logic             wb_valid,
    input  logic             wb_reg_we,
    input  logic [4:0]       wb_rd,
    input  logic             imem_stall,
    input  logic             dmem_stall,
    output logic             pc_sel_jump,
    output logic             stall_if,
    output logic             stall_ex,
    output logic             kill_id,
    output logic             kill_ex,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {RUN, FREEZE} state_t;

    state_t     state_q, state_d;
    logic       frozen;
    logic       ret_valid;
    logic [4:0] ret_rd;
    logic       ex_writes, redirect, load_use;

    assign ex_writes = ex_valid & ex_reg_we & (ex_rd != 5'd0);
    assign redirect  = ex_valid & ex_do_jump;
    assign load_use  = ex_writes & ex_is_load &
                       ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    // Younger producer (EX, about to enter WB) wins over the retire register.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (ex_writes && rs == ex_rd)
            return 2'b01;
        else if (ret_valid && ret_rd != 5'd0 && rs == ret_rd)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= RUN;
        else
            state_q <= state_d;
    end

    // dmem_stall freezes combinationally; the first cycle it drops already runs.
    always_comb begin
        state_d = state_q;
        frozen  = 1'b0;
        case (state_q)
            RUN: begin
                if (dmem_stall) begin
                    state_d = FREEZE;
                    frozen  = 1'b1;
                end
            end
            FREEZE: begin
                if (dmem_stall)
                    frozen = 1'b1;
                else
                    state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        pc_sel_jump = 1'b0;
        stall_if    = 1'b0;
        stall_ex    = 1'b0;
        kill_id     = 1'b0;
        kill_ex     = 1'b0;
        fwd_a_sel   = fwd_sel(id_rs1);
        fwd_b_sel   = fwd_sel(id_rs2);
        if (rst) begin
            kill_id   = 1'b1;
            kill_ex   = 1'b1;
            fwd_a_sel = 2'b00;
            fwd_b_sel = 2'b00;
        end else if (frozen) begin
            stall_if = 1'b1;
            stall_ex = 1'b1;
        end else if (redirect) begin
            pc_sel_jump = 1'b1;
            kill_id     = 1'b1;
            kill_ex     = 1'b1;
        end else if (load_use) begin
            stall_if = 1'b1;
            kill_ex  = 1'b1;
        end else if (imem_stall) begin
            stall_if = 1'b1;
            kill_id  = 1'b1;
        end
    end

    // Retire register covers the cycle between WB and the regfile write becoming visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            ret_valid <= 1'b0;
            ret_rd    <= 5'd0;
        end else if (!frozen) begin
            ret_valid <= wb_valid & wb_reg_we;
            ret_rd    <= wb_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_if | stall_ex)
                stall_cnt <= stall_cnt + 1'b1;
            if (pc_sel_jump)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule
